rf_wport_arbiter: RTL and testbench
===================================

# rf_wport_arbiter

Write-port arbiter and pending-write scoreboard for the 32×32 register file. It shares the register file's single write port between the pipeline writeback stage and a long-latency unit (divider/load return) using round-robin arbitration on contention, and presents one registered write to the register file per cycle. It also tracks destination registers of issued long-latency ops so decode can stall on read-after-write hazards.

## Interface
- No parameters; fixed 5-bit register address, 32-bit data.
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- wb_valid  in  1  writeback stage has a write
- wb_waddr  in  5  writeback destination
- wb_wdata  in  32  writeback data
- wb_ready  out  1  writeback write accepted this cycle when wb_valid
- lu_valid  in  1  long-latency unit has a result
- lu_waddr  in  5  long-latency destination
- lu_wdata  in  32  long-latency data
- lu_ready  out  1  long-latency write accepted this cycle when lu_valid
- issue_valid  in  1  long-latency op issued this cycle
- issue_waddr  in  5  its destination register
- flush  in  1  synchronous clear of scoreboard (exception/ertn)
- raddr1, raddr2  in  5 each  decode read addresses to check
- busy1, busy2  out  1 each  read address has a pending or in-flight write
- rf_we  out  1  registered write enable to register file
- rf_waddr  out  5  registered write address
- rf_wdata  out  32  registered write data
- sb_conflict  out  1  sticky: issue to an already-pending register

## Operation
- Grant logic is combinational. The rr_ptr register gives preference: 0 = wb, 1 = lu.
  - Only one of wb_valid/lu_valid high: that requester is granted.
  - Both high: the rr_ptr side is granted. rr_ptr then flips to the loser.
  - rr_ptr changes only on contention.
- wb_ready = !lu_valid | (rr_ptr==0). lu_ready = !wb_valid | (rr_ptr==1).
- Accepted write (valid & ready) registers into rf_we/rf_waddr/rf_wdata on the next edge.
  - rf_we = 1 only if the accepted waddr != 0. A write to r0 is accepted but dropped.
  - With no accepted write, rf_we = 0 and addr/data hold their previous values.
- Scoreboard: 32-bit pending vector; bit 0 is never set.
  - Set: issue_valid & issue_waddr != 0 sets pending[issue_waddr].
  - Clear: accepted lu write clears pending[lu_waddr].
  - Set and clear of the same bit in the same cycle: set wins.
  - Issue to an already-set bit: set sb_conflict (sticky until reset). The bit stays set.
  - flush clears every pending bit. Set/clear in the same cycle as flush are ignored. sb_conflict is unaffected.
- busyN = (raddrN != 0) & (pending[raddrN] | (rf_we & rf_waddr == raddrN)). This is combinational.
  - The output-stage term covers the cycle in which the register file has not yet absorbed the write.
- An lu result the issuer never scoreboarded (pending bit clear) is still written. The clear is then a no-op.

## Timing
- Reset (resetn low, asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0, pending=0, sb_conflict=0.
  - busy1/busy2 = 0 during reset. wb_ready/lu_ready follow the combinational rule with rr_ptr=0.
- Reset asserted mid-operation discards any accepted-but-unwritten write. No rf_we pulse occurs after release until a new acceptance.
- Latency: acceptance in cycle N produces rf_we high during cycle N+1. The register file captures it at the end of N+1.
- Throughput: one write per cycle. Under sustained contention, grants strictly alternate.
- busy updates:
  - An issue in cycle N makes busy visible in N+1.
  - An lu acceptance in N clears pending in N+1, but busy stays high through N+1 via the rf_we term. It drops in N+2.
- An issue and a busy query of the same register in the same cycle returns that cycle's prior state; there is no combinational bypass of issue.

## Test plan
- Reset, then an lone wb write: wb_valid=1, waddr=5, wdata=0x12345678 → wb_ready=1. Next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678. The cycle after, rf_we=0.
- Contention for 4 cycles: wb (r1, 0xA) and lu (r2, 0xB) both valid, rr_ptr=0 → grants wb, lu, wb, lu. rf_waddr sequence is 1, 2, 1, 2, one cycle delayed.
- Scoreboard path:
  - issue r7; next cycle raddr1=7 → busy1=1.
  - lu write r7 accepted in cycle N → busy1 stays 1 in N+1 (rf_we term) and is 0 in N+2.
- r0 handling:
  - wb write to r0 → wb_ready=1, rf_we stays 0.
  - issue r0 → pending unchanged; raddr1=0 gives busy1=0.
- Conflict and flush:
  - issue r3 twice → sb_conflict=1 and stays 1.
  - flush → busy on r3 = 0, sb_conflict still 1.
  - issue r4 together with flush → r4 not pending.
- Asynchronous reset asserted mid-stream, one cycle after a wb acceptance → rf_we=0 immediately, pending cleared, no write after resetn rises.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter (writeback vs long-latency unit)
// with a pending-write scoreboard for decode RAW hazard stalls.
module rf_wport_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic        wb_ready,
  input  logic        lu_valid,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_waddr,
  input  logic        flush,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        busy1,
  output logic        busy2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        sb_conflict
);

  logic        rr_ptr;
  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic        wb_acc;
  logic        lu_acc;
  logic        contend;
  logic        any_acc;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic        issue_nz;
  logic        issue_hit;

  // rr_ptr names the side preferred when both request
  assign wb_ready = !lu_valid | !rr_ptr;
  assign lu_ready = !wb_valid | rr_ptr;
  assign wb_acc   = wb_valid & wb_ready;
  assign lu_acc   = lu_valid & lu_ready;
  assign contend  = wb_valid & lu_valid;
  assign any_acc  = wb_acc | lu_acc;

  // at most one side is accepted, so a 2:1 mux suffices
  assign sel_addr = lu_acc ? lu_waddr : wb_waddr;
  assign sel_data = lu_acc ? lu_wdata : wb_wdata;

  assign issue_nz  = issue_valid & (issue_waddr != 5'd0);
  assign issue_hit = issue_nz & pending[issue_waddr];

  // scoreboard next state: flush dominates, then set beats clear
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_nz)
      set_vec[issue_waddr] = 1'b1;
    if (lu_acc)
      clr_vec[lu_waddr] = 1'b1;
    if (flush)
      pending_nxt = '0;
    else
      pending_nxt = (pending & ~clr_vec) | set_vec;
    pending_nxt[0] = 1'b0;
  end

  // round-robin pointer flips to the loser on contention only
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      rr_ptr <= 1'b0;
    else if (contend)
      rr_ptr <= ~rr_ptr;
  end

  // registered write toward the register file; r0 writes are dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (any_acc) begin
      rf_we    <= (sel_addr != 5'd0);
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // pending-write vector and sticky double-issue flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending     <= '0;
      sb_conflict <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (issue_hit)
        sb_conflict <= 1'b1;
    end
  end

  // busy covers pending ops and the write still sitting in the output stage
  always_comb begin
    busy1 = (raddr1 != 5'd0) &
            (pending[raddr1] | (rf_we & (rf_waddr == raddr1)));
    busy2 = (raddr2 != 5'd0) &
            (pending[raddr2] | (rf_we & (rf_waddr == raddr2)));
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed testbench for rf_wport_arbiter.
// Inputs change 1ns after posedge; outputs sampled away from the edge.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_ready;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic        flush;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        busy1;
  logic        busy2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_conflict;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  rf_wport_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .wb_valid    (wb_valid),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .wb_ready    (wb_ready),
    .lu_valid    (lu_valid),
    .lu_waddr    (lu_waddr),
    .lu_wdata    (lu_wdata),
    .lu_ready    (lu_ready),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .flush       (flush),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .busy1       (busy1),
    .busy2       (busy2),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .sb_conflict (sb_conflict)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    wb_valid = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h1;
    lu_valid = 1'b1; lu_waddr = 5'd4; lu_wdata = 32'h2;
    issue_valid = 1'b0; issue_waddr = 5'd0;
    flush = 1'b0; raddr1 = 5'd3; raddr2 = 5'd4;
    step();
    step();
    total_cnt++;
    if (rf_we !== 1'b0) $display("FAIL rst_we got %b want 0", rf_we);
    else pass_cnt++;
    total_cnt++;
    if (rf_waddr !== 5'd0) $display("FAIL rst_waddr got %0d want 0", rf_waddr);
    else pass_cnt++;
    total_cnt++;
    if (rf_wdata !== 32'd0) $display("FAIL rst_wdata got %h want 0", rf_wdata);
    else pass_cnt++;
    total_cnt++;
    if ({busy1, busy2} !== 2'b00) $display("FAIL rst_busy got %b want 00", {busy1, busy2});
    else pass_cnt++;
    total_cnt++;
    if (sb_conflict !== 1'b0) $display("FAIL rst_conf got %b want 0", sb_conflict);
    else pass_cnt++;
    total_cnt++;
    if ({wb_ready, lu_ready} !== 2'b10) $display("FAIL rst_ready got %b want 10", {wb_ready, lu_ready});
    else pass_cnt++;
    wb_valid = 1'b0;
    lu_valid = 1'b0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    total_cnt++;
    if ({wb_ready, lu_ready} !== 2'b11) $display("FAIL idle_ready got %b want 11", {wb_ready, lu_ready});
    else pass_cnt++;
    resetn = 1'b1;
    step();
  endtask

  task automatic test_lone_wb();
    wb_valid = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h12345678;
    #1;
    total_cnt++;
    if (wb_ready !== 1'b1) $display("FAIL wb_ready got %b want 1", wb_ready);
    else pass_cnt++;
    step();
    wb_valid = 1'b0;
    total_cnt++;
    if ({rf_we, rf_waddr} !== {1'b1, 5'd5}) $display("FAIL wb_out got %b/%0d want 1/5", rf_we, rf_waddr);
    else pass_cnt++;
    total_cnt++;
    if (rf_wdata !== 32'h12345678) $display("FAIL wb_data got %h want 12345678", rf_wdata);
    else pass_cnt++;
    step();
    total_cnt++;
    if (rf_we !== 1'b0) $display("FAIL wb_we_drop got %b want 0", rf_we);
    else pass_cnt++;
    total_cnt++;
    if (rf_waddr !== 5'd5) $display("FAIL wb_hold got %0d want 5", rf_waddr);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [4:0]  exp_a [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
    logic [31:0] exp_d [4] = '{32'hA, 32'hB, 32'hA, 32'hB};
    logic [1:0]  exp_r [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    wb_valid = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'hA;
    lu_valid = 1'b1; lu_waddr = 5'd2; lu_wdata = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++;
      if ({wb_ready, lu_ready} !== exp_r[i])
        $display("FAIL cont_grant%0d got %b want %b", i, {wb_ready, lu_ready}, exp_r[i]);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, exp_a[i], exp_d[i]})
        $display("FAIL cont_out%0d got %b/%0d/%h want 1/%0d/%h",
                 i, rf_we, rf_waddr, rf_wdata, exp_a[i], exp_d[i]);
      else pass_cnt++;
    end
    wb_valid = 1'b0;
    lu_valid = 1'b0;
    step();
    total_cnt++;
    if (rf_we !== 1'b0) $display("FAIL cont_idle got %b want 0", rf_we);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_waddr = 5'd7;
    raddr1 = 5'd7; raddr2 = 5'd8;
    #1;
    total_cnt++;
    if (busy1 !== 1'b0) $display("FAIL sb_nobypass got %b want 0", busy1);
    else pass_cnt++;
    step();
    issue_valid = 1'b0;
    total_cnt++;
    if ({busy1, busy2} !== 2'b10) $display("FAIL sb_set got %b want 10", {busy1, busy2});
    else pass_cnt++;
    lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h77;
    #1;
    total_cnt++;
    if (lu_ready !== 1'b1) $display("FAIL sb_lu_ready got %b want 1", lu_ready);
    else pass_cnt++;
    step();
    lu_valid = 1'b0;
    total_cnt++;
    if (busy1 !== 1'b1) $display("FAIL sb_hold got %b want 1", busy1);
    else pass_cnt++;
    total_cnt++;
    if ({rf_we, rf_waddr} !== {1'b1, 5'd7}) $display("FAIL sb_lu_out got %b/%0d want 1/7", rf_we, rf_waddr);
    else pass_cnt++;
    step();
    total_cnt++;
    if (busy1 !== 1'b0) $display("FAIL sb_clear got %b want 0", busy1);
    else pass_cnt++;
  endtask

  task automatic test_r0();
    wb_valid = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hDEAD;
    #1;
    total_cnt++;
    if (wb_ready !== 1'b1) $display("FAIL r0_ready got %b want 1", wb_ready);
    else pass_cnt++;
    step();
    wb_valid = 1'b0;
    total_cnt++;
    if (rf_we !== 1'b0) $display("FAIL r0_we got %b want 0", rf_we);
    else pass_cnt++;
    issue_valid = 1'b1; issue_waddr = 5'd0;
    step();
    issue_valid = 1'b0;
    raddr1 = 5'd0;
    #1;
    total_cnt++;
    if (busy1 !== 1'b0) $display("FAIL r0_busy got %b want 0", busy1);
    else pass_cnt++;
    total_cnt++;
    if (sb_conflict !== 1'b0) $display("FAIL r0_conf got %b want 0", sb_conflict);
    else pass_cnt++;
  endtask

  task automatic test_conflict_flush();
    issue_valid = 1'b1; issue_waddr = 5'd3;
    raddr1 = 5'd3;
    step();
    total_cnt++;
    if (sb_conflict !== 1'b0) $display("FAIL cf_first got %b want 0", sb_conflict);
    else pass_cnt++;
    step();
    issue_valid = 1'b0;
    total_cnt++;
    if ({sb_conflict, busy1} !== 2'b11) $display("FAIL cf_second got %b want 11", {sb_conflict, busy1});
    else pass_cnt++;
    step();
    total_cnt++;
    if (sb_conflict !== 1'b1) $display("FAIL cf_sticky got %b want 1", sb_conflict);
    else pass_cnt++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    total_cnt++;
    if ({sb_conflict, busy1} !== 2'b10) $display("FAIL cf_flush got %b want 10", {sb_conflict, busy1});
    else pass_cnt++;
    issue_valid = 1'b1; issue_waddr = 5'd4; flush = 1'b1;
    step();
    issue_valid = 1'b0; flush = 1'b0;
    raddr1 = 5'd4;
    #1;
    total_cnt++;
    if (busy1 !== 1'b0) $display("FAIL cf_issue_flush got %b want 0", busy1);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    wb_valid = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h99;
    issue_valid = 1'b1; issue_waddr = 5'd10;
    step();
    wb_valid = 1'b0; issue_valid = 1'b0;
    raddr1 = 5'd10; raddr2 = 5'd9;
    #1;
    total_cnt++;
    if ({rf_we, busy1, busy2} !== 3'b111) $display("FAIL ar_pre got %b want 111", {rf_we, busy1, busy2});
    else pass_cnt++;
    resetn = 1'b0;
    #1;
    total_cnt++;
    if (rf_we !== 1'b0) $display("FAIL ar_we got %b want 0", rf_we);
    else pass_cnt++;
    total_cnt++;
    if ({busy1, busy2} !== 2'b00) $display("FAIL ar_busy got %b want 00", {busy1, busy2});
    else pass_cnt++;
    total_cnt++;
    if (sb_conflict !== 1'b0) $display("FAIL ar_conf got %b want 0", sb_conflict);
    else pass_cnt++;
    step();
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if ({rf_we, busy1} !== 2'b00) $display("FAIL ar_post%0d got %b want 00", i, {rf_we, busy1});
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_lone_wb();
    test_contention();
    test_scoreboard();
    test_r0();
    test_conflict_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
